// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sequencer and the mux_control consumers.
package fft_pkg;

  localparam int NUMSTAGES = 5;
  localparam int NPOINTS   = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    FINISH  = 3'd4
  } fft_state_t;

  localparam logic [2:0] STAGE0 = 3'd0;
  localparam logic [2:0] STAGE1 = 3'd1;
  localparam logic [2:0] STAGE2 = 3'd2;
  localparam logic [2:0] STAGE3 = 3'd3;
  localparam logic [2:0] STAGE4 = 3'd4;

  // Wraps back to the first stage after the last one instead of overflowing.
  function automatic logic [2:0] next_stage(input logic [2:0] stage, input logic [2:0] last);
    return (stage == last) ? STAGE0 : stage + 3'd1;
  endfunction

  // Stage codes the mux_control decoders understand for the default transform size.
  function automatic logic is_valid_stage(input logic [2:0] stage);
    case (stage)
      STAGE0, STAGE1, STAGE2, STAGE3, STAGE4: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fft_step_counter.sv
// Intra-stage step counter plus butterfly stage index, with hold enable and clear.
module fft_step_counter #(
  parameter int NUMSTAGES = fft_pkg::NUMSTAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  output logic [NUMSTAGES-3:0] counter,
  output logic [2:0]           stage_num,
  output logic                 last
);
  import fft_pkg::*;

  localparam int                   CNT_W      = NUMSTAGES - 2;
  localparam logic [CNT_W-1:0]     CNT_ZERO   = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]     CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [2:0]           STAGE_LAST = 3'(NUMSTAGES - 1);

  logic [CNT_W-1:0] counter_r;
  logic [2:0]       stage_r;

  // Step/stage register: wrap the step index and advance the stage, never past the last stage.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      counter_r <= CNT_ZERO;
      stage_r   <= STAGE0;
    end else if (en) begin
      if (counter_r == CNT_MAX) begin
        counter_r <= CNT_ZERO;
        stage_r   <= next_stage(stage_r, STAGE_LAST);
      end else begin
        counter_r <= counter_r + CNT_ONE;
      end
    end
  end

  assign counter   = counter_r;
  assign stage_num = stage_r;
  assign last      = (counter_r == CNT_MAX) && (stage_r == STAGE_LAST);

endmodule

// File: rtl/fft_sequencer.sv
// Control sequencer for an in-place radix-2 FFT: load, compute stages, drain, done pulse.
module fft_sequencer #(
  parameter int NUMSTAGES = fft_pkg::NUMSTAGES,
  parameter int NPOINTS   = fft_pkg::NPOINTS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 out_ready,
  output logic                 ld_data,
  output logic [NUMSTAGES-3:0] counter,
  output logic [2:0]           stage_num,
  output logic                 in_ready,
  output logic [NUMSTAGES-1:0] sample_idx,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);
  import fft_pkg::*;

  localparam logic [NUMSTAGES-1:0] IDX_ZERO = NUMSTAGES'(32'd0);
  localparam logic [NUMSTAGES-1:0] IDX_ONE  = NUMSTAGES'(32'd1);
  localparam logic [NUMSTAGES-1:0] IDX_LAST = NUMSTAGES'(NPOINTS - 1);

  fft_state_t           state_r, state_s;
  logic [NUMSTAGES-1:0] sample_idx_r, sample_idx_s;
  logic                 step_en_s, step_clr_s, step_last_s;
  logic                 ld_data_r, in_ready_r, out_valid_r, busy_r, done_r;

  fft_step_counter #(.NUMSTAGES(NUMSTAGES)) u_step (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (step_clr_s),
    .en        (step_en_s),
    .counter   (counter),
    .stage_num (stage_num),
    .last      (step_last_s)
  );

  // Next-state and address logic; the step counter is held cleared outside COMPUTE.
  always_comb begin
    state_s      = state_r;
    sample_idx_s = sample_idx_r;
    step_en_s    = 1'b0;
    step_clr_s   = 1'b1;
    case (state_r)
      IDLE: begin
        if (start) state_s = LOAD;
        else       state_s = IDLE;
      end
      LOAD: begin
        if (in_valid) begin
          sample_idx_s = sample_idx_r + IDX_ONE;
          if (sample_idx_r == IDX_LAST) state_s = COMPUTE;
          else                          state_s = LOAD;
        end else begin
          state_s = LOAD;
        end
      end
      COMPUTE: begin
        step_clr_s = 1'b0;
        step_en_s  = !stall;
        if (!stall && step_last_s) state_s = DRAIN;
        else                       state_s = COMPUTE;
      end
      DRAIN: begin
        if (out_ready) begin
          sample_idx_s = sample_idx_r + IDX_ONE;
          if (sample_idx_r == IDX_LAST) state_s = FINISH;
          else                          state_s = DRAIN;
        end else begin
          state_s = DRAIN;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s      = IDLE;
        sample_idx_s = IDX_ZERO;
      end
    endcase
  end

  // State, address and output flops; outputs are decoded from the next state so they are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      sample_idx_r <= IDX_ZERO;
      ld_data_r    <= 1'b0;
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      sample_idx_r <= sample_idx_s;
      ld_data_r    <= (state_s == LOAD);
      in_ready_r   <= (state_s == LOAD);
      out_valid_r  <= (state_s == DRAIN);
      busy_r       <= (state_s != IDLE);
      done_r       <= (state_s == FINISH);
    end
  end

  assign ld_data    = ld_data_r;
  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign sample_idx = sample_idx_r;

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer: a transaction-level model predicts every cycle's outputs.
module tb_fft_sequencer;

  localparam int NS          = 5;
  localparam int NPTS        = 32;
  localparam int SPS         = 8;
  localparam int STEPS_TOTAL = NS * SPS;

  localparam int P_IDLE = 0, P_LOAD = 1, P_COMP = 2, P_DRAIN = 3, P_FIN = 4;
  localparam int MODE_B2B = 0, MODE_GAP = 1, MODE_STALL = 2, MODE_NOISE = 3,
                 MODE_BLOCK = 4, MODE_RAND = 5;

  typedef struct packed {
    logic       ld;
    logic       ir;
    logic       ov;
    logic       bz;
    logic       dn;
    logic [4:0] idx;
    logic [2:0] st;
    logic [2:0] cnt;
  } outv_t;

  logic       clk, rst_n, start, in_valid, stall, out_ready;
  logic       ld_data, in_ready, out_valid, busy, done;
  logic [2:0] counter, stage_num;
  logic [4:0] sample_idx;

  fft_sequencer #(.NUMSTAGES(NS), .NPOINTS(NPTS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .stall      (stall),
    .out_ready  (out_ready),
    .ld_data    (ld_data),
    .counter    (counter),
    .stage_num  (stage_num),
    .in_ready   (in_ready),
    .sample_idx (sample_idx),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  outv_t exp_q[$];
  int    len_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  // reference model state
  int m_phase, m_loaded, m_steps, m_drained, m_stalls;
  bit gap_tog;
  int stall_left;

  // Push the outputs the current model phase must show, then advance the model by one clock.
  task automatic step(input logic r, input logic s, input logic iv, input logic st, input logic ordy);
    outv_t e;
    rst_n = r; start = s; in_valid = iv; stall = st; out_ready = ordy;
    e = '0;
    case (m_phase)
      P_LOAD:  begin e.ld = 1'b1; e.ir = 1'b1; e.bz = 1'b1; e.idx = 5'(m_loaded); end
      P_COMP:  begin e.bz = 1'b1; e.st = 3'(m_steps / SPS); e.cnt = 3'(m_steps % SPS); end
      P_DRAIN: begin e.ov = 1'b1; e.bz = 1'b1; e.idx = 5'(m_drained); end
      P_FIN:   begin e.bz = 1'b1; e.dn = 1'b1; end
      default: ;
    endcase
    exp_q.push_back(e);
    if (!r) begin
      m_phase = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE: if (s) begin m_phase = P_LOAD; m_loaded = 0; end
        P_LOAD: if (iv) begin
          m_loaded++;
          if (m_loaded == NPTS) begin m_phase = P_COMP; m_steps = 0; m_stalls = 0; end
        end
        P_COMP: if (st) m_stalls++;
                else begin
                  m_steps++;
                  if (m_steps == STEPS_TOTAL) begin m_phase = P_DRAIN; m_drained = 0; end
                end
        P_DRAIN: if (ordy) begin
          m_drained++;
          if (m_drained == NPTS) begin m_phase = P_FIN; len_q.push_back(STEPS_TOTAL + m_stalls); end
        end
        default: m_phase = P_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_one(input int mode);
    logic r, s, iv, st, ordy;
    r = 1'b1; s = 1'b0; iv = 1'b1; st = 1'b0; ordy = 1'b1;
    case (mode)
      MODE_GAP:   begin iv = gap_tog; gap_tog = ~gap_tog; end
      MODE_STALL: if (m_phase == P_COMP && m_steps == SPS + 7 && stall_left > 0) begin
                    st = 1'b1; stall_left--;
                  end
      MODE_NOISE: begin
                    if (m_phase != P_IDLE) s = 1'($urandom_range(0, 1));
                    if (m_phase != P_COMP) st = 1'($urandom_range(0, 1));
                    if (m_phase != P_LOAD) iv = 1'($urandom_range(0, 1));
                  end
      MODE_BLOCK: ordy = 1'b0;
      MODE_RAND:  begin
                    r    = ($urandom_range(0, 299) != 0);
                    s    = ($urandom_range(0, 9) == 0);
                    iv   = 1'($urandom_range(0, 1));
                    st   = ($urandom_range(0, 3) == 0);
                    ordy = 1'($urandom_range(0, 1));
                  end
      default: ;
    endcase
    step(r, s, iv, st, ordy);
  endtask

  task automatic run_until_idle(input int mode, input int maxc, input string name);
    int n = 0;
    while (m_phase != P_IDLE && n < maxc) begin drive_one(mode); n++; end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s_bound: actual %0d cycles without completing, required < %0d", name, n, maxc);
    end
  endtask

  task automatic run_cycles(input int mode, input int n);
    for (int i = 0; i < n; i++) drive_one(mode);
  endtask

  // Monitor: pops one expected output vector per cycle and checks compute latency at each done pulse.
  outv_t g, e;
  int    comp_len = 0;
  int    exp_len;
  always @(negedge clk) begin
    if (mon_en) begin
      g = {ld_data, in_ready, out_valid, busy, done, sample_idx, stage_num, counter};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t: actual output %h with no expectation queued", $time, g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL outputs t=%0t actual ld=%b ir=%b ov=%b busy=%b done=%b idx=%0d stage=%0d cnt=%0d required ld=%b ir=%b ov=%b busy=%b done=%b idx=%0d stage=%0d cnt=%0d",
                   $time, g.ld, g.ir, g.ov, g.bz, g.dn, g.idx, g.st, g.cnt,
                   e.ld, e.ir, e.ov, e.bz, e.dn, e.idx, e.st, e.cnt);
        end
      end
      if (busy && !ld_data && !out_valid && !done) comp_len++;
      else if (!busy || ld_data) comp_len = 0;
      if (done) begin
        checks++;
        if (len_q.size() == 0) begin
          errors++;
          $display("FAIL compute_len t=%0t: actual done pulse, required none", $time);
        end else begin
          exp_len = len_q.pop_front();
          if (comp_len != exp_len) begin
            errors++;
            $display("FAIL compute_len t=%0t: actual %0d cycles, required %0d", $time, comp_len, exp_len);
          end
        end
        comp_len = 0;
      end
    end
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; stall = 1'b0; out_ready = 1'b0;
    m_phase = P_IDLE; m_loaded = 0; m_steps = 0; m_drained = 0; m_stalls = 0;
    gap_tog = 1'b0; stall_left = 0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // back-to-back load, no stall, drain always ready
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run_until_idle(MODE_B2B, 200, "b2b");

    // start with a sample in IDLE, then every-other-cycle samples
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    gap_tog = 1'b0;
    run_until_idle(MODE_GAP, 300, "gap");

    // three stall cycles at stage 1 step 7
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    stall_left = 3;
    run_until_idle(MODE_STALL, 200, "stall");

    // start/stall/in_valid toggled in phases where they must be ignored
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    run_until_idle(MODE_NOISE, 200, "noise");

    // drain never accepted, then reset out of DRAIN
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycles(MODE_BLOCK, NPTS + STEPS_TOTAL + 20);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset at stage 2 step 5 with start held through reset release
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!(m_phase == P_COMP && m_steps == 2 * SPS + 5) && n < 200) begin drive_one(MODE_B2B); n++; end
      checks++;
      if (n >= 200) begin
        errors++;
        $display("FAIL reach_stage2_bound: actual %0d cycles, required < 200", n);
      end
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run_until_idle(MODE_B2B, 200, "after_reset");

    run_cycles(MODE_RAND, 3000);

    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 Parameter NUMSTAGES, default 5, number of radix-2 stages; transform length is 2**NUMSTAGES points.
REQ-002 Parameter NPOINTS, default 32, transform length; SHALL equal 2**NUMSTAGES.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request to begin one transform; sampled only in IDLE.
REQ-006 in_valid  input  1  one input sample is present this cycle.
REQ-007 stall  input  1  freezes compute progress while high.
REQ-008 out_ready  input  1  downstream accepts one result sample this cycle.
REQ-009 ld_data  output  1  high while input samples are being loaded; drives downstream mux select m0.
REQ-010 counter  output  NUMSTAGES-2  intra-stage step index, 0..2**(NUMSTAGES-2)-1.
REQ-011 stage_num  output  3  current butterfly stage, 0..NUMSTAGES-1.
REQ-012 in_ready  output  1  sample on in_valid is accepted this cycle.
REQ-013 sample_idx  output  NUMSTAGES  load/unload address, 0..NPOINTS-1.
REQ-014 out_valid  output  1  result sample at sample_idx is presented.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at the end of the transform.

Function
REQ-017 States SHALL be IDLE, LOAD, COMPUTE, DRAIN, FINISH.
REQ-018 IDLE: start=1 -> LOAD next cycle; a sample on in_valid in that same cycle SHALL NOT be accepted.
REQ-019 LOAD: ld_data=1, in_ready=1; each cycle with in_valid=1 increments sample_idx; the acceptance at sample_idx=NPOINTS-1 -> COMPUTE with stage_num=0, counter=0, sample_idx=0.
REQ-020 LOAD with in_valid=0 SHALL hold sample_idx; no timeout.
REQ-021 COMPUTE: ld_data=0; each cycle with stall=0 increments counter; stall=1 holds counter and stage_num unchanged.
REQ-022 Counter at maximum with stall=0 wraps to 0 and increments stage_num; at stage_num=NUMSTAGES-1 it instead -> DRAIN with counter=0, stage_num=0.
REQ-023 stage_num SHALL never take values >= NUMSTAGES (downstream decodes those as undefined).
REQ-024 Compute latency without stall SHALL be exactly NUMSTAGES*2**(NUMSTAGES-2) cycles (40 for defaults).
REQ-025 DRAIN: out_valid=1; each cycle with out_ready=1 increments sample_idx; acceptance at NPOINTS-1 -> FINISH.
REQ-026 FINISH: done=1 for exactly one cycle, then IDLE.
REQ-027 start outside IDLE SHALL be ignored; in_valid outside LOAD SHALL be ignored; stall outside COMPUTE SHALL be ignored.
REQ-028 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path except none.
REQ-029 ld_data SHALL be 0 in every state other than LOAD.

Reset
REQ-030 rst_n=0 at a rising edge, in any state including mid-transform, SHALL force IDLE next cycle.
REQ-031 Reset values: ld_data=0, counter=0, stage_num=0, in_ready=0, sample_idx=0, out_valid=0, busy=0, done=0.
REQ-032 start held high through reset release SHALL enter LOAD on the first edge with rst_n=1.

Structure
REQ-033 State encoding, NUMSTAGES, NPOINTS and stage constants STAGE0..STAGE4 SHALL reside in shared package fft_pkg, also used by mux_control consumers.
REQ-034 One sub-module fft_step_counter (counter plus stage_num with wrap/advance and hold enable) SHALL be instantiated; FSM stays in fft_sequencer.

Verification
REQ-035 Reset mid-COMPUTE (stage 2, counter 5) -> next cycle IDLE, all outputs at reset values.
REQ-036 start, 32 back-to-back in_valid, no stall, out_ready=1 -> COMPUTE lasts 40 cycles, stage_num steps 0..4, DRAIN 32 cycles, done pulses once.
REQ-037 in_valid gapped every other cycle -> sample_idx advances only on valid cycles; COMPUTE entered after 32nd acceptance.
REQ-038 stall=1 for 3 cycles at stage 1 counter 7 -> counter/stage held, then wrap to stage 2 counter 0; total compute 43 cycles.
REQ-039 start and in_valid high together in IDLE -> that sample not counted; start pulsed during COMPUTE -> no effect.
REQ-040 out_ready=0 throughout DRAIN -> out_valid stays high, sample_idx held at 0, done never asserted.
